filter_run_ctrl: RTL

FILTER_RUN_CTRL -- requirements
Module: filter_run_ctrl

---
 rtl/gpu_ctrl_pkg.sv | 16 +
 rtl/mem_owner_mux.sv | 50 +++++
 rtl/filter_run_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/gpu_ctrl_pkg.sv
// Shared types for the filter run controller: FSM states and 3-lane data memory widths.
package gpu_ctrl_pkg;
  localparam int LANES  = 3;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 18;

  typedef logic [ADDR_W-1:0]             addr_t;
  typedef logic [LANES-1:0][DATA_W-1:0]  lane_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/mem_owner_mux.sv
// Combinational data-memory port mux: the filter core owns the memory while it runs,
// the host owns it otherwise.
module mem_owner_mux
  import gpu_ctrl_pkg::*;
(
  input  logic       core_owner,
  input  logic       start,
  input  logic       host_req,
  input  logic       host_we,
  input  addr_t      host_addr,
  input  lane_data_t host_wdata,
  output logic       host_gnt,
  output lane_data_t host_rdata,
  input  addr_t      core_A1,
  input  addr_t      core_A2,
  input  addr_t      core_A3,
  input  logic       core_we,
  input  lane_data_t core_wdata,
  output lane_data_t core_rdata,
  output addr_t      mem_A1,
  output addr_t      mem_A2,
  output addr_t      mem_A3,
  output logic       mem_we,
  output lane_data_t mem_wdata,
  input  lane_data_t mem_rdata
);

  // A start pulse takes priority over a host access in the same cycle.
  assign host_gnt   = !core_owner && host_req && !start;
  assign host_rdata = mem_rdata;
  assign core_rdata = mem_rdata;

  always_comb begin
    if (core_owner) begin
      mem_A1    = core_A1;
      mem_A2    = core_A2;
      mem_A3    = core_A3;
      mem_we    = core_we;
      mem_wdata = core_wdata;
    end else begin
      // Host lanes address three consecutive words; the 10-bit sum wraps naturally.
      mem_A1    = host_addr;
      mem_A2    = host_addr + addr_t'(1);
      mem_A3    = host_addr + addr_t'(2);
      mem_we    = host_gnt && host_we;
      mem_wdata = host_wdata;
    end
  end

endmodule

// File: rtl/filter_run_ctrl.sv
// Sequences one filter pass: holds the core in reset, runs it until halt or timeout,
// lets in-flight writes drain, then hands the data memory back to the host.
module filter_run_ctrl
  import gpu_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_PC      = 32'h0000_00FC,
  parameter logic [15:0] MAX_CYCLES   = 16'hFFFF,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       host_req,
  input  logic       host_we,
  input  addr_t      host_addr,
  input  lane_data_t host_wdata,
  output logic       host_gnt,
  output lane_data_t host_rdata,
  output logic       core_rst,
  input  logic [31:0] core_pc,
  input  addr_t      core_A1,
  input  addr_t      core_A2,
  input  addr_t      core_A3,
  input  logic       core_we,
  input  lane_data_t core_wdata,
  output lane_data_t core_rdata,
  output addr_t      mem_A1,
  output addr_t      mem_A2,
  output addr_t      mem_A3,
  output logic       mem_we,
  output lane_data_t mem_wdata,
  input  lane_data_t mem_rdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [15:0] cycle_count
);

  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

  state_t      state;
  logic [15:0] drain_cnt;
  logic        core_owner;

  assign core_owner = (state == RUN) || (state == DRAIN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      core_rst    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cycle_count <= '0;
      drain_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            core_rst    <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            cycle_count <= '0;
            drain_cnt   <= '0;
          end
        end
        RUN: begin
          if (cycle_count != 16'hFFFF)
            cycle_count <= cycle_count + 16'd1;
          // A halt seen in the timeout cycle is a clean finish, not an error.
          if (core_pc == HALT_PC) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else if (cycle_count == MAX_CYCLES) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            err       <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state    <= DONE;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          core_rst <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  mem_owner_mux u_mux (
    .core_owner (core_owner),
    .start      (start),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rdata (host_rdata),
    .core_A1    (core_A1),
    .core_A2    (core_A2),
    .core_A3    (core_A3),
    .core_we    (core_we),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .mem_A1     (mem_A1),
    .mem_A2     (mem_A2),
    .mem_A3     (mem_A3),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

endmodule
